dis_seg_driver: RTL and testbench

Display back end for the COA CPU: consumes the 8-bit `Dis` result bus produced by `Top_002` and shows it as a 3-digit unsigned decimal (0–255) on a multiplexed, common-anode seven-segment display. A sequential double-dabble converter turns each new `Dis` value into BCD. A prescaled scan counter then drives one digit at a time. The block sits directly downstream of `Top_002` at the board top level.

---
 rtl/dis_seg_driver.sv | 153 +++++++++++++++
 tb/tb_dis_seg_driver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dis_seg_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// dis_seg_driver: 8-bit value -> 3-digit decimal on a common-anode 7-seg mux.
// Option: define SEG_LZ_BLANK_EN to blank leading zeros.   Revision: 1.0
// ============================================================================
module dis_seg_driver #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] Dis,
  output logic [7:0] Seg,
  output logic [2:0] An,
  output logic       Busy
);

  localparam int            CW          = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] C_SCAN_LAST = CW'(SCAN_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;

  logic [7:0]    dis_q, dis_d, last_val_q, last_val_d, cap_q, cap_d;
  logic [1:0]    state_q, state_d;
  logic [19:0]   sr_q, sr_d, adj;
  logic [2:0]    bit_q, bit_d;
  logic [3:0]    hund_q, hund_d, tens_q, tens_d, unit_q, unit_d;
  logic [CW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;
  logic [3:0]    digit;
  logic          blank, blank_h, blank_t;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [7:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  assign dis_d = Dis;

  // Double-dabble: the display digits only change in LATCH, so a value
  // arriving mid-conversion never produces a mixed result.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_d      = bit_q;
    cap_d      = cap_q;
    last_val_d = last_val_q;
    hund_d     = hund_q;
    tens_d     = tens_q;
    unit_d     = unit_q;
    adj        = {add3(sr_q[19:16]), add3(sr_q[15:12]), add3(sr_q[11:8]), sr_q[7:0]};
    case (state_q)
      S_IDLE: begin
        if (dis_q != last_val_q) begin
          sr_d    = {12'b0, dis_q};
          bit_d   = 3'd0;
          cap_d   = dis_q;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d  = adj << 1;
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = S_LATCH;
      end
      S_LATCH: begin
        hund_d     = sr_q[19:16];
        tens_d     = sr_q[15:12];
        unit_d     = sr_q[11:8];
        last_val_d = cap_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pre_d = (pre_q == C_SCAN_LAST) ? '0 : pre_q + CW'(1);
    idx_d = idx_q;
    if (pre_q == C_SCAN_LAST) idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
`ifdef SEG_LZ_BLANK_EN
    blank_h = (hund_q == 4'd0);
    blank_t = blank_h && (tens_q == 4'd0);
`else
    blank_h = 1'b0;
    blank_t = 1'b0;
`endif
    case (idx_q)
      2'd0:    begin an_d = 3'b110; digit = unit_q; blank = 1'b0;    end
      2'd1:    begin an_d = 3'b101; digit = tens_q; blank = blank_t; end
      2'd2:    begin an_d = 3'b011; digit = hund_q; blank = blank_h; end
      default: begin an_d = 3'b111; digit = 4'd0;   blank = 1'b1;    end
    endcase
    seg_d = blank ? 8'hFF : dec7(digit);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dis_q      <= 8'd0;
      last_val_q <= 8'd0;
      cap_q      <= 8'd0;
      state_q    <= S_IDLE;
      sr_q       <= 20'd0;
      bit_q      <= 3'd0;
      hund_q     <= 4'd0;
      tens_q     <= 4'd0;
      unit_q     <= 4'd0;
      pre_q      <= '0;
      idx_q      <= 2'd0;
      seg_q      <= 8'hFF;
      an_q       <= 3'b111;
    end else begin
      dis_q      <= dis_d;
      last_val_q <= last_val_d;
      cap_q      <= cap_d;
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_q      <= bit_d;
      hund_q     <= hund_d;
      tens_q     <= tens_d;
      unit_q     <= unit_d;
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign Seg  = seg_q;
  assign An   = an_q;
  assign Busy = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dis_seg_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_dis_seg_driver: scoreboard bench; expected digit triples {h,t,u} are
// queued by the stimulus and checked per cycle by the display monitor.
// ============================================================================
module tb_dis_seg_driver;

  localparam int SCAN_DIV = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] Dis = 8'hAA;
  logic [7:0] Seg;
  logic [2:0] An;
  logic       Busy;

  int          checks   = 0;
  int          failures = 0;
  logic [23:0] exp_q[$];
  logic        mon_en   = 1'b0;

  localparam logic [23:0] E_170 = {8'hF9, 8'hF8, 8'hC0};
  localparam logic [23:0] E_255 = {8'hA4, 8'h92, 8'h92};
  localparam logic [23:0] E_100 = {8'hF9, 8'hC0, 8'hC0};
  localparam logic [23:0] E_200 = {8'hA4, 8'hC0, 8'hC0};
`ifdef SEG_LZ_BLANK_EN
  localparam logic [23:0] E_ZERO = {8'hFF, 8'hFF, 8'hC0};
  localparam logic [23:0] E_7    = {8'hFF, 8'hFF, 8'hF8};
  localparam logic [23:0] E_42   = {8'hFF, 8'h99, 8'hA4};
`else
  localparam logic [23:0] E_ZERO = {8'hC0, 8'hC0, 8'hC0};
  localparam logic [23:0] E_7    = {8'hC0, 8'hC0, 8'hF8};
  localparam logic [23:0] E_42   = {8'hC0, 8'h99, 8'hA4};
`endif

  dis_seg_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .Dis  (Dis),
    .Seg  (Seg),
    .An   (An),
    .Busy (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_an(input int k);
    case (((k - 1) / 4) % 3)
      0:       return 3'b110;
      1:       return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

  // Monitor: every cycle the enabled digit must show the current expected
  // triple; a conversion finishing (Busy falling) retires the next entry.
  logic [23:0] mon_cur       = E_ZERO;
  logic        mon_prev_busy = 1'b0;
  logic [7:0]  mon_want;

  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        case (An)
          3'b110:  mon_want = mon_cur[7:0];
          3'b101:  mon_want = mon_cur[15:8];
          3'b011:  mon_want = mon_cur[23:16];
          default: mon_want = 8'hFF;
        endcase
        check("seg_display", {24'd0, Seg}, {24'd0, mon_want});
        if (!RST) begin
          mon_cur = E_ZERO;
        end else if (mon_prev_busy && !Busy) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: actual=conversion_done required=none_pending");
          end else begin
            mon_cur = exp_q.pop_front();
          end
        end
        mon_prev_busy = Busy;
      end
    end
  end

  task automatic wait_busy_fall(input string name);
    bit seen = 1'b0;
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge CLK); #1;
      if (Busy) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s: actual=timeout required=busy_fall_within_60", name);
    end
  endtask

  task automatic apply(input logic [7:0] v, input logic [23:0] e, input string name);
    @(posedge CLK); #2;
    exp_q.push_back(e);
    Dis = v;
    wait_busy_fall(name);
    repeat (14) @(posedge CLK);
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int rise;
    int fall;

    repeat (5) begin
      @(posedge CLK); #1;
      check("rst_an",   {29'd0, An},   32'h6 + 32'h1);
      check("rst_seg",  {24'd0, Seg},  32'hFF);
      check("rst_busy", {31'd0, Busy}, 32'd0);
      mon_en = 1'b1;
    end

    // Release reset; Dis=170 is already waiting.
    @(posedge CLK); #2;
    exp_q.push_back(E_170);
    RST = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      check("scan_an", {29'd0, An}, {29'd0, exp_an(k)});
      if (k == 1) check("first_seg", {24'd0, Seg}, 32'hC0);
    end
    repeat (14) @(posedge CLK);

    // Full-scale value with Busy window measured edge by edge.
    @(posedge CLK); #2;
    exp_q.push_back(E_255);
    Dis = 8'd255;
    rise = -1;
    fall = -1;
    for (int k = 0; k < 14; k++) begin
      @(posedge CLK); #1;
      if (Busy && rise < 0) rise = k;
      if (!Busy && rise >= 0 && fall < 0) fall = k;
    end
    check("busy_rise_edge", rise, 1);
    check("busy_fall_edge", fall, 10);
    repeat (14) @(posedge CLK);

    apply(8'd7,   E_7,    "conv_7");
    apply(8'd100, E_100,  "conv_100");
    apply(8'd0,   E_ZERO, "conv_0");

    // Input change on the 4th SHIFT cycle.
    @(posedge CLK); #2;
    exp_q.push_back(E_100);
    exp_q.push_back(E_42);
    Dis = 8'd100;
    repeat (5) @(posedge CLK);
    #2;
    check("busy_midconv", {31'd0, Busy}, 32'd1);
    Dis = 8'd42;
    wait_busy_fall("first_pulse");
    @(posedge CLK); #1;
    check("busy_restart", {31'd0, Busy}, 32'd1);
    wait_busy_fall("second_pulse");
    repeat (14) @(posedge CLK);

    // Asynchronous reset pulse in the middle of SHIFT.
    @(posedge CLK); #2;
    exp_q.push_back(E_200);
    Dis = 8'd200;
    repeat (4) @(posedge CLK);
    #2;
    check("busy_before_rst", {31'd0, Busy}, 32'd1);
    RST = 1'b0;
    #1;
    check("arst_seg",  {24'd0, Seg},  32'hFF);
    check("arst_an",   {29'd0, An},   32'h7);
    check("arst_busy", {31'd0, Busy}, 32'd0);
    @(posedge CLK); #2;
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("post_rst_an",  {29'd0, An},  32'h6);
    check("post_rst_seg", {24'd0, Seg}, 32'hC0);
    wait_busy_fall("reconvert");
    repeat (14) @(posedge CLK);

    check("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
